morph_seq_ctrl: RTL and testbench

- Sequences the 3x3 binary morphology window datapath (line buffers, window registers, output delay) for one frame of an H_ACTIVE x V_ACTIVE binary image.
- Sits between the binary-threshold pixel source and the frame writer.
- Generates the datapath shift enable and gates it with valid/ready backpressure on both sides.
- Selects dilate, erode or bypass per frame, flushes the pipeline after the last input pixel, and reports frame completion.

---
 rtl/morph_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_morph_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/morph_seq_ctrl.sv
// Sequencing controller for the 3x3 binary morphology window datapath.
// It drives the shift enable and serial input of the datapath. It applies
// valid/ready backpressure on both the source side and the sink side. The
// operation (dilate, erode or bypass) is chosen once per frame. After the last
// input pixel it flushes the pipeline, and it pulses frame_done when the
// frame is complete.
//
// Ports:
//   CLK, RST            clock; synchronous active-low reset
//   start, mode         frame start pulse and operation select (00/11 bypass,
//                       01 dilate, 10 erode), both taken in IDLE only
//   in_valid/in_ready   source handshake, carries in_pixel
//   shift_en, dp_data   datapath shift enable and serial input
//   dp_result           datapath serial output
//   out_valid/out_ready sink handshake, carries out_pixel and out_last
//   busy, frame_done    registered status
module morph_seq_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned ALIGN_LAT = 962
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_pixel,
    output logic       shift_en,
    output logic       dp_data,
    input  logic       dp_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_pixel,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W     = 19;
    localparam int unsigned SCNT_W    = 20;
    localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PIX_TOTAL - 1);
    localparam logic [SCNT_W-1:0] ALIGN    = SCNT_W'(ALIGN_LAT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [SCNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic morph;
    logic erode;
    logic emit;
    logic src_ok;

    // Next-state, counters and handshake outputs
    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        shift_cnt_d  = shift_cnt_q;
        mode_d       = mode_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_pixel    = 1'b0;
        out_last     = 1'b0;
        shift_en     = 1'b0;
        dp_data      = 1'b0;
        src_ok       = 1'b0;
        morph        = (mode_q == 2'b01) || (mode_q == 2'b10);
        erode        = (mode_q == 2'b10);
        emit         = (shift_cnt_q >= ALIGN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    shift_cnt_d = '0;
                    state_d     = ((mode == 2'b01) || (mode == 2'b10)) ? S_FILL : S_RUN;
                end
            end

            S_FILL, S_RUN, S_FLUSH: begin
                if (!morph) begin
                    // Bypass: straight-through handshake, datapath idle
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_pixel = in_pixel;
                    out_last  = in_valid && (in_cnt_q == LAST_IDX);
                    if (in_valid && out_ready) begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                        if (in_cnt_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    // Erode runs as dilate of the complement; flush pads with 0
                    src_ok    = (state_q == S_FLUSH) ? 1'b1 : in_valid;
                    in_ready  = (state_q != S_FLUSH) && (!emit || out_ready);
                    shift_en  = src_ok && (!emit || out_ready);
                    out_valid = emit && src_ok;
                    dp_data   = (state_q == S_FLUSH) ? 1'b0 : (in_pixel ^ erode);
                    out_pixel = dp_result ^ erode;
                    out_last  = out_valid && (out_cnt_q == LAST_IDX);
                    if (shift_en) begin
                        if (!emit) begin
                            shift_cnt_d = shift_cnt_q + SCNT_W'(1);
                        end
                        if (state_q != S_FLUSH) begin
                            in_cnt_d = in_cnt_q + CNT_W'(1);
                            if (in_cnt_q == LAST_IDX) begin
                                state_d = S_FLUSH;
                            end else if ((state_q == S_FILL) && (shift_cnt_d >= ALIGN)) begin
                                state_d = S_RUN;
                            end
                        end
                        // A shift while emitting is always a sink transfer
                        if (emit) begin
                            out_cnt_d = out_cnt_q + CNT_W'(1);
                            if (out_cnt_q == LAST_IDX) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State and status registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            shift_cnt_q  <= '0;
            mode_q       <= 2'b00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            shift_cnt_q  <= shift_cnt_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_morph_seq_ctrl.sv
// Directed bench for morph_seq_ctrl on an 8x4 frame with ALIGN_LAT=10.
// The datapath is modelled as a plain 10-stage delay line, so each result
// pixel equals its input pixel. Inputs are driven on the falling edge and
// outputs are sampled 1 ns later.
module tb_morph_seq_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AL = 10;
    localparam int N  = H * V;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic       in_pixel;
    logic       shift_en;
    logic       dp_data;
    logic       dp_result;
    logic       out_valid;
    logic       out_ready;
    logic       out_pixel;
    logic       out_last;
    logic       busy;
    logic       frame_done;

    morph_seq_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ALIGN_LAT(AL)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .shift_en  (shift_en),
        .dp_data   (dp_data),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: delay line clocked by shift_en, cleared by RST
    logic [AL-1:0] dl;
    always_ff @(posedge clk) begin
        if (!rst) dl <= '0;
        else if (shift_en) dl <= {dl[AL-2:0], dp_data};
    end
    assign dp_result = dl[AL-1];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Per-frame observations
    logic [N-1:0] got;
    int n_out, last_pos, last_cnt, done_cyc, last_cyc;
    bit done_seen, aborted;
    bit bad_bypass, bad_flush, bad_stall, bad_early, bad_noxfer;

    // vmode: 0 always valid, 1 every other cycle, 2 random
    // rmode: 0 always ready, 1 random
    task automatic run_frame(input logic [1:0] md, input logic [N-1:0] pix,
                             input int vmode, input int rmode, input int stall_at,
                             input int poke_cyc, input int abort_at);
        int in_idx = 0;
        int n_shift = 0;
        int stall_left = 0;
        bit stalled_once = 0;
        got = '0; n_out = 0; last_pos = -1; last_cnt = 0; done_cyc = -1; last_cyc = -1;
        done_seen = 0; aborted = 0;
        bad_bypass = 0; bad_flush = 0; bad_stall = 0; bad_early = 0; bad_noxfer = 0;
        @(negedge clk);
        start = 1'b1; mode = md; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (abort_at >= 0 && n_out == abort_at) begin
                aborted = 1;
                break;
            end
            if (stall_at >= 0 && !stalled_once && n_out == stall_at) begin
                stall_left = 5;
                stalled_once = 1;
            end
            start = (cyc == poke_cyc);
            if (cyc == poke_cyc) mode = 2'b00;
            case (vmode)
                0:       in_valid = (in_idx < N);
                1:       in_valid = (in_idx < N) && (cyc % 2 == 0);
                default: in_valid = (in_idx < N) && ($urandom_range(0, 1) == 1);
            endcase
            in_pixel = (in_idx < N) ? pix[in_idx] : 1'b0;
            if (stall_left > 0) out_ready = 1'b0;
            else if (rmode == 0) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (frame_done) begin
                done_seen = 1;
                done_cyc = cyc;
                break;
            end
            if (md == 2'b00 && shift_en) bad_bypass = 1;
            if (shift_en && in_idx >= N && dp_data !== 1'b0) bad_flush = 1;
            if (shift_en && in_idx < N && !(in_valid && in_ready)) bad_noxfer = 1;
            if (out_valid && n_shift < AL) bad_early = 1;
            if (stall_left > 0 && n_shift >= AL && (shift_en || in_ready)) bad_stall = 1;
            if (in_valid && in_ready) in_idx++;
            if (out_valid && out_ready) begin
                if (n_out < N) got[n_out] = out_pixel;
                if (out_last) begin
                    last_pos = n_out;
                    last_cnt++;
                end
                n_out++;
                last_cyc = cyc;
            end
            if (shift_en) n_shift++;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [N-1:0] p5;
    logic [19:0]  lo_got, lo_exp;
    logic [N-1:0] p6;

    initial begin
        rst = 1'b0; start = 1'b0; mode = 2'b00;
        in_valid = 1'b1; in_pixel = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_shift_en",   32'(shift_en),   32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_dp_data",    32'(dp_data),    32'd0);
        rst = 1'b1;

        // Dilate, single 1 at pixel 13, both sides always ready
        run_frame(2'b01, 32'h0000_2000, 0, 0, -1, -1, -1);
        check("dil_data",      got,              32'h0000_2000);
        check("dil_count",     32'(n_out),       32'd32);
        check("dil_last_pos",  32'(last_pos),    32'd31);
        check("dil_last_cnt",  32'(last_cnt),    32'd1);
        check("dil_done_seen", 32'(done_seen),   32'd1);
        check("dil_done_lag",  32'(done_cyc),    32'(last_cyc + 1));
        check("dil_frame_cyc", 32'(done_cyc),    32'd42);
        check("dil_noxfer",    32'(bad_noxfer),  32'd0);
        // start during DONE must be ignored
        start = 1'b1; mode = 2'b01;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_start_busy", 32'(busy),       32'd0);
        check("done_pulse_once", 32'(frame_done), 32'd0);

        // Erode, all-ones input
        run_frame(2'b10, 32'hFFFF_FFFF, 0, 0, -1, -1, -1);
        check("ero_data",     got,             32'hFFFF_FFFF);
        check("ero_flush_dp", 32'(bad_flush),  32'd0);
        check("ero_count",    32'(n_out),      32'd32);
        check("ero_last_pos", 32'(last_pos),   32'd31);

        // Dilate with a 5-cycle sink stall at the 7th output
        run_frame(2'b01, 32'hA5C3_0F96, 0, 0, 6, -1, -1);
        check("stall_data",      got,             32'hA5C3_0F96);
        check("stall_hold",      32'(bad_stall),  32'd0);
        check("stall_count",     32'(n_out),      32'd32);
        check("stall_frame_cyc", 32'(done_cyc),   32'd47);

        // Dilate with 50% source valid
        run_frame(2'b01, 32'h3C5A_96E1, 1, 0, -1, -1, -1);
        check("half_data",   got,             32'h3C5A_96E1);
        check("half_early",  32'(bad_early),  32'd0);
        check("half_noxfer", 32'(bad_noxfer), 32'd0);

        // Bypass with random pixels, random valid and random ready
        p5 = $urandom;
        run_frame(2'b00, p5, 2, 1, -1, -1, -1);
        check("byp_data",      got,             p5);
        check("byp_no_shift",  32'(bad_bypass), 32'd0);
        check("byp_count",     32'(n_out),      32'd32);
        check("byp_last_pos",  32'(last_pos),   32'd31);
        check("byp_done_seen", 32'(done_seen),  32'd1);

        // Dilate aborted by reset at output 20, with a bypass start poked mid-frame
        p6 = 32'h0F0F_1234;
        run_frame(2'b01, p6, 0, 0, -1, 3, 20);
        lo_got = got[19:0];
        lo_exp = p6[19:0];
        check("abort_reached", 32'(aborted),   32'd1);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_data",    32'(lo_got),    32'(lo_exp));
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_busy",       32'(busy),       32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        check("abort_in_ready",   32'(in_ready),   32'd0);
        check("abort_shift_en",   32'(shift_en),   32'd0);
        rst = 1'b1;
        run_frame(2'b01, 32'h8000_0001, 0, 0, -1, -1, -1);
        check("restart_data",      got,            32'h8000_0001);
        check("restart_count",     32'(n_out),     32'd32);
        check("restart_done_seen", 32'(done_seen), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
